// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Framing receiver that sits ahead of the byte-wide holding register in the
// serial datapath. It takes one line bit per clock and does no oversampling.
// It finds a start bit and shifts DATA_W data bits in LSB first. When
// PARITY_EN is set it checks a parity bit. It then checks the stop bit and
// presents each good word under a valid/ack handshake. All flops update on
// the falling edge of clk.
//
// Ports
//   clk         in   1       clock, falling-edge active
//   rst         in   1       asynchronous active-high reset
//   sin         in   1       serial line, idles high
//   data_ack    in   1       consumer accepts data_out while data_valid=1
//   data_out    out  DATA_W  last good word, bit0 = first data bit received
//   data_valid  out  1       data_out holds an unacknowledged word
//   busy        out  1       registered (state != IDLE)
//   frame_err   out  1       one-clock pulse: stop bit sampled low
//   parity_err  out  1       one-clock pulse: parity mismatch
//   overrun     out  1       sticky: a word replaced an unacknowledged word
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [CNT_W-1:0]    bitCnt_q;
  logic                parityBad_q;
  logic                parityBad_d;
  logic                loadWord_d;

  // The XOR of the data bits and the parity bit must equal the configured
  // sense (1 for odd parity, 0 for even parity).
  assign parityBad_d = ((^shreg_q) ^ sin) != (PARITY_ODD != 0);

  // A word is delivered only when the stop bit is high and the parity
  // recorded for this frame was good.
  assign loadWord_d  = (state_q == STOP) && sin && !parityBad_q;

  // This block holds the framing FSM, the shift register and the handshake
  // outputs together. Every output is registered. The error pulses default
  // to 0, so each one lasts exactly one clock after the STOP edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitCnt_q    <= '0;
      parityBad_q <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= (state_q != IDLE);

      // A load takes priority over an ack. A load while a word is still
      // pending and unacknowledged is an overrun. An ack on the same edge
      // as a load simply hands over to the new word.
      if (loadWord_d) begin
        data_out   <= shreg_q;
        data_valid <= 1'b1;
        if (data_valid && !data_ack) begin
          overrun <= 1'b1;
        end else if (data_ack) begin
          overrun <= 1'b0;
        end
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_q  <= DATA;
            bitCnt_q <= '0;
          end
        end
        DATA: begin
          // New bits enter at the MSB, so the first bit received ends up
          // in bit 0 once all DATA_W bits are in.
          shreg_q  <= {sin, shreg_q[DATA_W-1:1]};
          bitCnt_q <= bitCnt_q + 1'b1;
          if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          parityBad_q <= parityBad_d;
          state_q     <= STOP;
        end
        STOP: begin
          // A bad stop bit hides any parity result for the same frame.
          if (!sin) begin
            frame_err <= 1'b1;
          end else if (parityBad_q) begin
            parity_err <= 1'b1;
          end
          parityBad_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
